ram_2r1w_clr: RTL and testbench
===============================

# ram_2r1w_clr

Parametrised successor to the single-port word RAM. It has one write port with per-lane write mask and two independent registered read ports, each with a valid flag. Write-first forwarding applies when a read and write hit the same address in the same cycle. A built-in clear sequencer zeroes the whole array on request. It sits wherever the design needs a small register file, for example the genotype/fitness scratch stores, and replaces direct arrays of `Word` instances.

## Interface
Parameters:
- `Width`, 8: bits per word; must be a multiple of `Lanes`.
- `AddressSize`, 4: address bits; depth is 2**AddressSize.
- `Lanes`, 1: write-mask lanes; each lane is Width/Lanes bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  start clear sweep; sampled only in IDLE.
- `busy`  out  1  high while the clear sweep runs.
- `we`  in  1  write enable.
- `waddr`  in  AddressSize  write address.
- `wmask`  in  Lanes  per-lane write enable; lane i covers bits [(i+1)*LW-1 : i*LW].
- `D`  in  Width  write data.
- `re_a`, `re_b`  in  1  read enables, ports A/B.
- `raddr_a`, `raddr_b`  in  AddressSize  read addresses.
- `Qa`, `Qb`  out  Width  registered read data.
- `va`, `vb`  out  1  read-valid, one cycle after the accepted read.

## Operation
- Reset (rst=0, async):
  - All words are 0.
  - `Qa`=`Qb`=0, `va`=`vb`=0, `busy`=0.
  - FSM is in IDLE and the sweep counter is 0.
- Write (IDLE, `we`=1, `clr`=0): at the edge, lanes with `wmask[i]`=1 take D's lane; other lanes keep their value.
- `we`=1 with `wmask`=0 is a no-op.
- Read, per port, independently:
  - With `re`=1 at edge N: Q takes mem[raddr] and v=1 after edge N.
  - With `re`=0: Q holds its last value and v=0.
- Forwarding (write-first): if a read address equals the effective write address in the same cycle, Q returns the merged word. Masked lanes come from the new data and unmasked lanes from the old contents.
  - This applies to host writes and to sweep writes (sweep writes count as data 0, full mask).
- Both ports may read the same address in the same cycle; both return identical data.
- FSM states:
  - IDLE: `clr`=1 moves to CLEAR with counter=0.
  - CLEAR: each cycle writes 0 to mem[counter] and increments the counter. The transition CLEAR→IDLE happens at the edge where the counter equals 2**AddressSize-1; the counter wraps to 0.
- Simultaneous events and priorities:
  - `clr` and `we` both high in IDLE: `clr` wins and the host write is dropped.
  - `we` is ignored for the whole of CLEAR.
  - `clr` is ignored while in CLEAR; there is no restart.
  - Reads are serviced during CLEAR. Words already swept, or swept that cycle, read 0; unswept words read old contents.
- Reset mid-sweep: array goes to 0, `busy`=0 immediately, FSM goes to IDLE.

## Timing
- Read latency is 1 cycle: address at edge N, data and valid after edge N.
- Write is visible to a read issued at the same edge (forwarding) and to all later reads.
- Clear sweep:
  - `clr` sampled at edge N gives `busy`=1 after edge N.
  - Word k is zeroed at edge N+1+k.
  - `busy`=0 after edge N+2**AddressSize, so the sweep takes exactly 2**AddressSize cycles.
- The first host write is accepted at edge N+2**AddressSize+1.
- There are no combinational paths from inputs to outputs; all outputs are registered.

## Structure
- Package `ram_pkg`: function `lane_width(Width,Lanes)`, a mask-merge function `merge(old,new,mask)`, and FSM state encoding (IDLE=1'b0, CLEAR=1'b1).
- Sub-module `word_masked`: one storage word with async active-low reset and a per-lane enable. It is instantiated 2**AddressSize times in a generate loop.
- The top level contains the write decode (one-hot select ANDed with effective enable), the sweep counter and FSM, and the two read/forward registers.
- An elaboration check fails if Width % Lanes != 0.

## Test plan
- **Reset values:** hold rst=0 for 2 cycles with random inputs, then release. Expect all outputs 0; reading every address on both ports returns 0.
- **Masked write:** Width=8, Lanes=2.
  - Write 0xAB to addr 3 with mask 2'b11, then 0xCD with mask 2'b01.
  - Read addr 3 next cycle: Qa=0xAD, va=1.
- **Forwarding:** same cycle: `we`, waddr=5, D=0x5A, mask=2'b10, with re_a/re_b on addr 5 (old contents 0x11).
  - Expect Qa=Qb=0x51 after the edge.
- **Clear sweep:** fill all 16 words with 0xFF, then pulse `clr`.
  - Expect busy=1 for exactly 16 cycles.
  - Reading addr 0 at sweep cycle 2 gives 0; reading addr 15 at sweep cycle 2 gives 0xFF.
  - A `we` to addr 7 during the sweep is dropped, so addr 7 reads 0 afterwards.
- **clr+we collision:** in IDLE assert clr and we (addr 2, 0x77) together. Expect the sweep to run and addr 2 = 0 afterwards.
- **Reset mid-sweep:** assert rst=0 at sweep cycle 5. Expect busy=0 at once, all words 0, and a write accepted on the first edge after release.

Source files
------------

// File: rtl/ram_2r1w_clr_pkg.sv
// ram_pkg: shared helpers for the two-read/one-write clearable RAM.
//   lane_width(width, lanes) : bits per write-mask lane
//   merge(old, new, bits)    : bitwise mask merge on a MaxWidth-wide carrier;
//                              callers size-cast operands in and the result out
//   state_t                  : clear sequencer state (IDLE=0, CLEAR=1)
package ram_pkg;

  // Upper bound on the word width the merge helper can carry.
  localparam int unsigned MaxWidth = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int unsigned lane_width(input int unsigned width,
                                             input int unsigned lanes);
    if (lanes == 32'd0) begin
      return 32'd0;
    end else begin
      return width / lanes;
    end
  endfunction

  // Bits set in bit_mask come from new_word, the rest keep old_word.
  function automatic logic [MaxWidth-1:0] merge(input logic [MaxWidth-1:0] old_word,
                                                input logic [MaxWidth-1:0] new_word,
                                                input logic [MaxWidth-1:0] bit_mask);
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/ram_2r1w_clr_word_masked.sv
// word_masked: one storage word split into independently enabled lanes.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears the word to 0
//   en   : per-lane load enable
//   d    : write data
//   q    : stored word
module word_masked
  import ram_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Lanes = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Lanes-1:0] en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  localparam int unsigned LaneW = lane_width(Width, Lanes);

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    logic [LaneW-1:0] lane_r;

    // Lane storage: loads its slice of d only when its enable is set
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_r <= {LaneW{1'b0}};
      end else if (en[l]) begin
        lane_r <= d[l*LaneW +: LaneW];
      end
    end

    assign q[l*LaneW +: LaneW] = lane_r;
  end

endmodule

// File: rtl/ram_2r1w_clr.sv
// ram_2r1w_clr: register file with one lane-masked write port, two registered
// read ports with write-first forwarding, and a built-in clear sweep.
//   clk, rst           : clock, asynchronous active-low reset
//   clr / busy         : start clear sweep (taken in IDLE) / sweep running
//   we, waddr, wmask, D: host write (ignored during the sweep)
//   re_a/raddr_a -> Qa, va : read port A, one-cycle latency
//   re_b/raddr_b -> Qb, vb : read port B, one-cycle latency
module ram_2r1w_clr
  import ram_pkg::*;
#(
  parameter int unsigned Width       = 8,
  parameter int unsigned AddressSize = 4,
  parameter int unsigned Lanes       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  output logic                   busy,
  input  logic                   we,
  input  logic [AddressSize-1:0] waddr,
  input  logic [Lanes-1:0]       wmask,
  input  logic [Width-1:0]       D,
  input  logic                   re_a,
  input  logic                   re_b,
  input  logic [AddressSize-1:0] raddr_a,
  input  logic [AddressSize-1:0] raddr_b,
  output logic [Width-1:0]       Qa,
  output logic [Width-1:0]       Qb,
  output logic                   va,
  output logic                   vb
);

  localparam int unsigned Depth = 2**AddressSize;
  localparam int unsigned LaneW = lane_width(Width, Lanes);

  if ((Width % Lanes) != 32'd0) begin : g_bad_lanes
    $error("ram_2r1w_clr: Width must be a multiple of Lanes");
  end
  if (Width > MaxWidth) begin : g_bad_width
    $error("ram_2r1w_clr: Width exceeds ram_pkg::MaxWidth");
  end

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [AddressSize-1:0] cnt_r;
  logic [AddressSize-1:0] cnt_nxt_s;

  // Effective write: either the host write or the sweep's zero write.
  logic [AddressSize-1:0] wr_addr_s;
  logic [Width-1:0]       wr_data_s;
  logic [Lanes-1:0]       wr_lanes_s;
  logic [Width-1:0]       wr_bits_s;

  logic [Lanes-1:0]       word_en_s [Depth];
  logic [Width-1:0]       mem_s     [Depth];

  logic [Width-1:0]       rd_a_s;
  logic [Width-1:0]       rd_b_s;
  logic [Width-1:0]       qa_r;
  logic [Width-1:0]       qb_r;
  logic                   va_r;
  logic                   vb_r;

  // Select the write source; clr in IDLE suppresses the host write
  always_comb begin
    wr_addr_s  = waddr;
    wr_data_s  = D;
    wr_lanes_s = {Lanes{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (we && !clr) begin
          wr_lanes_s = wmask;
        end else begin
          wr_lanes_s = {Lanes{1'b0}};
        end
      end
      ST_CLEAR: begin
        wr_addr_s  = cnt_r;
        wr_data_s  = {Width{1'b0}};
        wr_lanes_s = {Lanes{1'b1}};
      end
      default: begin
        wr_lanes_s = {Lanes{1'b0}};
      end
    endcase
  end

  for (genvar l = 0; l < Lanes; l++) begin : g_bits
    assign wr_bits_s[l*LaneW +: LaneW] = {LaneW{wr_lanes_s[l]}};
  end

  // One-hot word decode gated by the effective lane enables.
  for (genvar k = 0; k < Depth; k++) begin : g_word
    assign word_en_s[k] = (wr_addr_s == AddressSize'(k)) ? wr_lanes_s : {Lanes{1'b0}};

    word_masked #(
      .Width (Width),
      .Lanes (Lanes)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .en  (word_en_s[k]),
      .d   (wr_data_s),
      .q   (mem_s[k])
    );
  end

  // Read data with write-first forwarding of the word being written this cycle
  always_comb begin
    rd_a_s = mem_s[raddr_a];
    rd_b_s = mem_s[raddr_b];
    if (raddr_a == wr_addr_s) begin
      rd_a_s = Width'(merge(MaxWidth'(mem_s[raddr_a]), MaxWidth'(wr_data_s), MaxWidth'(wr_bits_s)));
    end else begin
      rd_a_s = mem_s[raddr_a];
    end
    if (raddr_b == wr_addr_s) begin
      rd_b_s = Width'(merge(MaxWidth'(mem_s[raddr_b]), MaxWidth'(wr_data_s), MaxWidth'(wr_bits_s)));
    end else begin
      rd_b_s = mem_s[raddr_b];
    end
  end

  // Read registers: Q holds when not reading, valid pulses for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa_r <= {Width{1'b0}};
      qb_r <= {Width{1'b0}};
      va_r <= 1'b0;
      vb_r <= 1'b0;
    end else begin
      va_r <= re_a;
      vb_r <= re_b;
      if (re_a) begin
        qa_r <= rd_a_s;
      end
      if (re_b) begin
        qb_r <= rd_b_s;
      end
    end
  end

  // Sweep sequencer next state: one word per cycle, leaves after the last word
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clr) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {AddressSize{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Counter wraps to 0 on the final word.
        cnt_nxt_s = cnt_r + AddressSize'(1'b1);
        if (cnt_r == {AddressSize{1'b1}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {AddressSize{1'b0}};
      end
    endcase
  end

  // Sweep sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {AddressSize{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign busy = (state_r == ST_CLEAR);
  assign Qa   = qa_r;
  assign Qb   = qb_r;
  assign va   = va_r;
  assign vb   = vb_r;

endmodule

// File: tb/tb_ram_2r1w_clr.sv
// Self-checking bench for ram_2r1w_clr (Width=8, AddressSize=4, Lanes=2).
// The reference model is an array plus a "words left to sweep" count.
module tb_ram_2r1w_clr;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int L     = 2;
  localparam int LW    = W / L;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          we = 1'b0;
  logic          re_a = 1'b0;
  logic          re_b = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr_a = '0;
  logic [AW-1:0] raddr_b = '0;
  logic [L-1:0]  wmask = '0;
  logic [W-1:0]  D = '0;
  logic [W-1:0]  Qa;
  logic [W-1:0]  Qb;
  logic          busy;
  logic          va;
  logic          vb;

  always #5 clk = ~clk;

  ram_2r1w_clr #(
    .Width       (W),
    .AddressSize (AW),
    .Lanes       (L)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .we      (we),
    .waddr   (waddr),
    .wmask   (wmask),
    .D       (D),
    .re_a    (re_a),
    .re_b    (re_b),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .Qa      (Qa),
    .Qb      (Qb),
    .va      (va),
    .vb      (vb)
  );

  // Reference model state
  logic [W-1:0] ref_mem [DEPTH];
  int           sweep_left;
  logic [W-1:0] exp_qa, exp_qb;
  logic         exp_va, exp_vb, exp_busy;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    sweep_left = 0;
    exp_qa = '0; exp_qb = '0;
    exp_va = 1'b0; exp_vb = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    waddr = '0; raddr_a = '0; raddr_b = '0; wmask = '0; D = '0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then
  // clock the DUT and settle 1 time unit past the edge.
  task automatic tick();
    int           wa;
    logic [W-1:0] wd;
    logic [L-1:0] wm;
    logic [W-1:0] merged;
    wa = 0; wd = '0; wm = '0;
    if (sweep_left > 0) begin
      wa = DEPTH - sweep_left; wd = '0; wm = '1;
    end else if (we && !clr) begin
      wa = int'(waddr); wd = D; wm = wmask;
    end
    merged = ref_mem[wa];
    for (int l = 0; l < L; l++)
      if (wm[l]) merged[l*LW +: LW] = wd[l*LW +: LW];
    if (re_a) exp_qa = (int'(raddr_a) == wa) ? merged : ref_mem[raddr_a];
    if (re_b) exp_qb = (int'(raddr_b) == wa) ? merged : ref_mem[raddr_b];
    exp_va = re_a;
    exp_vb = re_b;
    ref_mem[wa] = merged;
    if (sweep_left > 0) sweep_left = sweep_left - 1;
    else if (clr) sweep_left = DEPTH;
    exp_busy = (sweep_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      clr = 1'($urandom); we = 1'($urandom); re_a = 1'($urandom); re_b = 1'($urandom);
      waddr = AW'($urandom); raddr_a = AW'($urandom); raddr_b = AW'($urandom);
      wmask = L'($urandom); D = W'($urandom);
    end
    total++;
    if ({Qa, Qb, va, vb, busy} !== {{(2*W){1'b0}}, 3'b000}) begin
      bad++;
      $display("FAIL reset_outputs: got Qa=%h Qb=%h va=%b vb=%b busy=%b want all 0", Qa, Qb, va, vb, busy);
    end
    model_reset();
    idle();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      re_a = 1'b1; re_b = 1'b1; raddr_a = AW'(i); raddr_b = AW'(DEPTH - 1 - i);
      tick();
      total++;
      if ({Qa, Qb, va, vb} !== {exp_qa, exp_qb, exp_va, exp_vb}) begin
        bad++;
        $display("FAIL reset_read[%0d]: got Qa=%h Qb=%h va=%b vb=%b want %h %h %b %b",
                 i, Qa, Qb, va, vb, exp_qa, exp_qb, exp_va, exp_vb);
      end
    end
    idle();
  endtask

  task automatic test_masked_write();
    we = 1'b1; waddr = 4'd3; D = 8'hAB; wmask = 2'b11; tick();
    we = 1'b1; waddr = 4'd3; D = 8'hCD; wmask = 2'b01; tick();
    idle(); re_a = 1'b1; raddr_a = 4'd3; tick();
    total++;
    if (Qa !== exp_qa || va !== 1'b1) begin
      bad++;
      $display("FAIL masked_write: got Qa=%h va=%b want Qa=%h va=1", Qa, va, exp_qa);
    end
    idle(); tick();
    total++;
    if (va !== 1'b0 || Qa !== exp_qa) begin
      bad++;
      $display("FAIL read_hold: got Qa=%h va=%b want Qa=%h va=0", Qa, va, exp_qa);
    end
  endtask

  task automatic test_forward();
    we = 1'b1; waddr = 4'd5; D = 8'h11; wmask = 2'b11; tick();
    we = 1'b1; waddr = 4'd5; D = 8'h5A; wmask = 2'b10;
    re_a = 1'b1; re_b = 1'b1; raddr_a = 4'd5; raddr_b = 4'd5;
    tick();
    total++;
    if ({Qa, Qb, va, vb} !== {exp_qa, exp_qb, 2'b11}) begin
      bad++;
      $display("FAIL forward: got Qa=%h Qb=%h va=%b vb=%b want %h %h 1 1", Qa, Qb, va, vb, exp_qa, exp_qb);
    end
    idle();
  endtask

  task automatic test_clear_sweep();
    int busy_cycles;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; waddr = AW'(i); D = 8'hFF; wmask = 2'b11; tick();
    end
    idle(); clr = 1'b1; tick(); clr = 1'b0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < 24; c++) begin
      idle();
      if (c == 2) begin
        re_a = 1'b1; raddr_a = 4'd0; re_b = 1'b1; raddr_b = 4'd15;
      end
      if (c == 10) begin
        we = 1'b1; waddr = 4'd7; D = 8'h99; wmask = 2'b11;
      end
      tick();
      if (busy === 1'b1) busy_cycles++;
      total++;
      if ({Qa, Qb, va, vb, busy} !== {exp_qa, exp_qb, exp_va, exp_vb, exp_busy}) begin
        bad++;
        $display("FAIL sweep_cycle[%0d]: got Qa=%h Qb=%h va=%b vb=%b busy=%b want %h %h %b %b %b",
                 c, Qa, Qb, va, vb, busy, exp_qa, exp_qb, exp_va, exp_vb, exp_busy);
      end
    end
    total++;
    if (busy_cycles != DEPTH) begin
      bad++;
      $display("FAIL sweep_length: got %0d busy cycles want %0d", busy_cycles, DEPTH);
    end
    idle(); re_a = 1'b1; raddr_a = 4'd7; tick();
    total++;
    if (Qa !== exp_qa || va !== 1'b1) begin
      bad++;
      $display("FAIL sweep_we_dropped: got Qa=%h va=%b want Qa=%h va=1", Qa, va, exp_qa);
    end
    idle();
  endtask

  task automatic test_clr_we_collision();
    we = 1'b1; waddr = 4'd2; D = 8'h33; wmask = 2'b11; tick();
    clr = 1'b1; we = 1'b1; waddr = 4'd2; D = 8'h77; wmask = 2'b11; tick();
    total++;
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL collision_busy: got %b want %b", busy, exp_busy);
    end
    idle();
    repeat (DEPTH + 2) tick();
    re_a = 1'b1; raddr_a = 4'd2; re_b = 1'b1; raddr_b = 4'd2; tick();
    total++;
    if ({Qa, Qb, busy} !== {exp_qa, exp_qb, exp_busy}) begin
      bad++;
      $display("FAIL collision_addr2: got Qa=%h Qb=%h busy=%b want %h %h %b", Qa, Qb, busy, exp_qa, exp_qb, exp_busy);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      clr = ($urandom_range(49) == 0);
      we = 1'($urandom); waddr = AW'($urandom); wmask = L'($urandom); D = W'($urandom);
      re_a = 1'($urandom); re_b = 1'($urandom);
      raddr_a = AW'($urandom); raddr_b = ($urandom_range(3) == 0) ? raddr_a : AW'($urandom);
      tick();
      total++;
      if ({Qa, Qb, va, vb, busy} !== {exp_qa, exp_qb, exp_va, exp_vb, exp_busy}) begin
        bad++;
        $display("FAIL random[%0d]: got Qa=%h Qb=%h va=%b vb=%b busy=%b want %h %h %b %b %b",
                 n, Qa, Qb, va, vb, busy, exp_qa, exp_qb, exp_va, exp_vb, exp_busy);
      end
    end
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; waddr = AW'(i); D = W'($urandom) | 8'h01; wmask = 2'b11; tick();
    end
    idle(); re_a = 1'b1; raddr_a = 4'd12; tick();
    idle(); clr = 1'b1; tick(); clr = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    model_reset();
    total++;
    if ({Qa, va, vb, busy} !== {exp_qa, exp_va, exp_vb, exp_busy}) begin
      bad++;
      $display("FAIL midsweep_reset: got Qa=%h va=%b vb=%b busy=%b want 0 0 0 0", Qa, va, vb, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    we = 1'b1; waddr = 4'd9; D = 8'h3C; wmask = 2'b11;
    re_a = 1'b1; raddr_a = 4'd9; re_b = 1'b1; raddr_b = 4'd10;
    tick();
    total++;
    if ({Qa, Qb, va, vb} !== {exp_qa, exp_qb, exp_va, exp_vb}) begin
      bad++;
      $display("FAIL post_reset_write: got Qa=%h Qb=%h va=%b vb=%b want %h %h %b %b",
               Qa, Qb, va, vb, exp_qa, exp_qb, exp_va, exp_vb);
    end
    for (int i = 0; i < DEPTH; i++) begin
      idle(); re_a = 1'b1; raddr_a = AW'(i); re_b = 1'b1; raddr_b = AW'(DEPTH - 1 - i);
      tick();
      total++;
      if ({Qa, Qb} !== {exp_qa, exp_qb}) begin
        bad++;
        $display("FAIL post_reset_read[%0d]: got Qa=%h Qb=%h want %h %h", i, Qa, Qb, exp_qa, exp_qb);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_masked_write();
    test_forward();
    test_clear_sweep();
    test_clr_we_collision();
    test_random();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
